// File: rtl/bram_fifo_pkg.sv
// Shared definitions for the BRAM-backed FIFO controller: output-buffer state
// encoding and the pointer/count width helpers.
package bram_fifo_pkg;

  typedef enum logic [1:0] {
    OB_EMPTY = 2'd0,
    OB_ONE   = 2'd1,
    OB_TWO   = 2'd2
  } ob_state_t;

  // Pointers carry one extra wrap bit; the count must reach DEPTH+2.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int cnt_width(input int addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/bram_fifo_outbuf.sv
// Two-entry first-word-fall-through buffer that absorbs the RAM read latency.
// Entry e0 is always the oldest word; returns append at the tail.
module bram_fifo_outbuf
  import bram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ret_valid,
  input  logic [DATA_WIDTH-1:0] ret_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic [1:0]            ob_cnt
);

  ob_state_t             state_reg, state_next;
  logic [DATA_WIDTH-1:0] e0_reg, e0_next;
  logic [DATA_WIDTH-1:0] e1_reg, e1_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= OB_EMPTY;
      e0_reg    <= '0;
      e1_reg    <= '0;
    end else begin
      state_reg <= state_next;
      e0_reg    <= e0_next;
      e1_reg    <= e1_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    e0_next    = e0_reg;
    e1_next    = e1_reg;
    case (state_reg)
      OB_EMPTY: begin
        if (ret_valid) begin
          e0_next    = ret_data;
          state_next = OB_ONE;
        end
      end
      OB_ONE: begin
        if (ret_valid && pop) begin
          e0_next = ret_data;
        end else if (ret_valid) begin
          e1_next    = ret_data;
          state_next = OB_TWO;
        end else if (pop) begin
          state_next = OB_EMPTY;
        end
      end
      OB_TWO: begin
        // The read-issue rule never lets a return arrive here without a pop.
        if (pop) begin
          e0_next = e1_reg;
          if (ret_valid) e1_next = ret_data;
          else           state_next = OB_ONE;
        end
      end
      default: state_next = OB_EMPTY;
    endcase
  end

  assign out_valid = (state_reg != OB_EMPTY);
  assign out_data  = out_valid ? e0_reg : '0;
  assign ob_cnt    = state_reg;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller driving an external dual-port BRAM (A = write, B = read).
// Optional sticky ovf/udf error flags are built when BRAM_FIFO_ERR_EN is defined.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  empty,
`ifdef BRAM_FIFO_ERR_EN
  output logic                  ovf,
  output logic                  udf,
`endif
  output logic                  mem_en,
  output logic                  mem_a_wr,
  output logic [ADDR_WIDTH-1:0] mem_a_addr,
  output logic [DATA_WIDTH-1:0] mem_a_data,
  output logic                  mem_b_wr,
  output logic [ADDR_WIDTH-1:0] mem_b_addr,
  output logic [DATA_WIDTH-1:0] mem_b_data_in,
  input  logic [DATA_WIDTH-1:0] mem_b_data_out
);

  localparam int PW    = ptr_width(ADDR_WIDTH);
  localparam int CW    = cnt_width(ADDR_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [PW-1:0] wp_reg, rp_reg;
  logic [PW-1:0] mem_cnt;
  logic          inflight_reg;
  logic          push, pop, issue;
  logic [1:0]    ob_cnt;

  assign mem_cnt  = wp_reg - rp_reg;
  assign in_ready = rst && (mem_cnt != PW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Only prefetch when the buffer will still have room once the read returns.
  assign issue = rst && (mem_cnt != '0) &&
                 (({1'b0, ob_cnt} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, pop}));

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_reg       <= '0;
      rp_reg       <= '0;
      inflight_reg <= 1'b0;
    end else begin
      wp_reg       <= wp_reg + PW'(push);
      rp_reg       <= rp_reg + PW'(issue);
      inflight_reg <= issue;
    end
  end

  bram_fifo_outbuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_outbuf (
    .clk      (clk),
    .rst      (rst),
    .ret_valid(inflight_reg),
    .ret_data (mem_b_data_out),
    .pop      (pop),
    .out_data (out_data),
    .out_valid(out_valid),
    .ob_cnt   (ob_cnt)
  );

  assign count = CW'(mem_cnt) + CW'(ob_cnt) + CW'(inflight_reg);
  assign empty = (count == '0);

  assign mem_en        = rst;
  assign mem_a_wr      = push;
  assign mem_a_addr    = push ? wp_reg[ADDR_WIDTH-1:0] : '0;
  assign mem_a_data    = push ? in_data : '0;
  assign mem_b_wr      = 1'b0;
  assign mem_b_addr    = issue ? rp_reg[ADDR_WIDTH-1:0] : '0;
  assign mem_b_data_in = '0;

`ifdef BRAM_FIFO_ERR_EN
  logic ovf_reg, udf_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_reg <= 1'b0;
      udf_reg <= 1'b0;
    end else begin
      if (in_valid && !in_ready)   ovf_reg <= 1'b1;
      if (out_ready && !out_valid) udf_reg <= 1'b1;
    end
  end

  assign ovf = ovf_reg;
  assign udf = udf_reg;
`endif

endmodule
